// File: rtl/mau_pkg.sv
// Shared types and helpers for the load/store initiator: size codes, FSM states,
// byte-lane enables and the alignment check.
package mau_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    // Big-endian lanes: bit 3 is byte offset 0 (bits [31:24])
    function automatic logic [BE_W-1:0] byte_en(input size_t size, input logic [1:0] offset);
        case (size)
            SZ_BYTE: return 4'b1000 >> offset;
            SZ_HALF: return offset[1] ? 4'b0011 : 4'b1100;
            SZ_WORD: return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic is_misaligned(input size_t size, input logic [1:0] offset);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return offset[0];
            SZ_WORD: return |offset;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/halfword out of a big-endian memory word and
// sign- or zero-extends it to 32 bits; word loads pass through.
module load_align
    import mau_pkg::*;
(
    input  logic [DATA_W-1:0] word,
    input  size_t             size,
    input  logic [1:0]        offset,
    input  logic              zero_ext,
    output logic [DATA_W-1:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[31:24];
        case (offset)
            2'd0: byte_sel = word[31:24];
            2'd1: byte_sel = word[23:16];
            2'd2: byte_sel = word[15:8];
            2'd3: byte_sel = word[7:0];
            default: byte_sel = word[31:24];
        endcase
        half_sel = offset[1] ? word[15:0] : word[31:16];

        result = word;
        case (size)
            SZ_BYTE: result = {{24{~zero_ext & byte_sel[7]}}, byte_sel};
            SZ_HALF: result = {{16{~zero_ext & half_sel[15]}}, half_sel};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator: one access at a time, word-aligned memory request with
// byte enables, fixed read latency, single-cycle registered response.
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_error,
    output logic              MemoryRead,
    output logic              MemoryWrite,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [BE_W-1:0]   mem_byte_en,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned CNT_W = $clog2(READ_LATENCY + 1);

    state_t            state;
    size_t             req_sz;
    size_t             size_q;
    logic              write_q;
    logic              zext_q;
    logic [1:0]        off_q;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] load_data;

    assign req_sz = size_t'(req_size);

    load_align u_load_align (
        .word     (mem_rdata),
        .size     (size_q),
        .offset   (off_q),
        .zero_ext (zext_q),
        .result   (load_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            req_ready   <= 1'b1;
            resp_valid  <= 1'b0;
            resp_error  <= 1'b0;
            resp_rdata  <= '0;
            MemoryRead  <= 1'b0;
            MemoryWrite <= 1'b0;
            mem_byte_en <= '0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            size_q      <= SZ_BYTE;
            write_q     <= 1'b0;
            zext_q      <= 1'b0;
            off_q       <= 2'd0;
            cnt         <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        size_q    <= req_sz;
                        write_q   <= req_write;
                        zext_q    <= req_unsigned;
                        off_q     <= req_addr[1:0];
                        // Misaligned/reserved requests never touch memory
                        if (is_misaligned(req_sz, req_addr[1:0])) begin
                            state      <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_error <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            state    <= ST_ISSUE;
                            mem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
                            if (req_write) begin
                                MemoryWrite <= 1'b1;
                                mem_byte_en <= byte_en(req_sz, req_addr[1:0]);
                                case (req_sz)
                                    SZ_BYTE: mem_wdata <= {4{req_wdata[7:0]}};
                                    SZ_HALF: mem_wdata <= {2{req_wdata[15:0]}};
                                    default: mem_wdata <= req_wdata;
                                endcase
                            end else begin
                                MemoryRead  <= 1'b1;
                                mem_byte_en <= 4'b1111;
                            end
                        end
                    end
                end
                ST_ISSUE: begin
                    MemoryRead  <= 1'b0;
                    MemoryWrite <= 1'b0;
                    mem_byte_en <= '0;
                    if (write_q) begin
                        state      <= ST_RESP;
                        resp_valid <= 1'b1;
                        resp_error <= 1'b0;
                        resp_rdata <= '0;
                    end else begin
                        state <= ST_WAIT;
                        cnt   <= CNT_W'(READ_LATENCY);
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state      <= ST_RESP;
                        resp_valid <= 1'b1;
                        resp_error <= 1'b0;
                        resp_rdata <= load_data;
                    end
                end
                ST_RESP: begin
                    state      <= ST_IDLE;
                    resp_valid <= 1'b0;
                    resp_error <= 1'b0;
                    req_ready  <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: two instances (read latency 1 and 3) share request
// stimulus, each with its own memory model and response scoreboard.
module tb_mem_access_unit;

    typedef struct {
        int          due;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [1:0]  valid;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        mon_en;
    logic        rst_chk;
    logic        end_chk;

    int n_pass  = 0;
    int n_total = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int unsigned RL = (g == 0) ? 1 : 3;

        logic        rdy, rv, rerr, mrd, mwr;
        logic [31:0] rdat, maddr, mwd, mrdat;
        logic [3:0]  be;

        mem_access_unit #(.READ_LATENCY(RL)) u_dut (
            .clk          (clk),
            .rst          (rst),
            .req_valid    (valid[g]),
            .req_ready    (rdy),
            .req_write    (req_write),
            .req_size     (req_size),
            .req_unsigned (req_unsigned),
            .req_addr     (req_addr),
            .req_wdata    (req_wdata),
            .resp_valid   (rv),
            .resp_rdata   (rdat),
            .resp_error   (rerr),
            .MemoryRead   (mrd),
            .MemoryWrite  (mwr),
            .mem_addr     (maddr),
            .mem_wdata    (mwd),
            .mem_byte_en  (be),
            .mem_rdata    (mrdat)
        );

        logic [31:0] mem     [64];
        logic [31:0] ref_mem [64];
        logic [31:0] word_l;
        int          left;

        initial begin
            for (int i = 0; i < 64; i++) begin
                mem[i]     = 32'h0;
                ref_mem[i] = 32'h0;
            end
            left  = 0;
            mrdat = 32'hA5A5_5A5A;
        end

        // Memory: read data is valid for exactly one cycle, RL cycles after the strobe cycle
        always @(posedge clk) begin
            mrdat <= 32'hA5A5_5A5A;
            if (left == 1) mrdat <= word_l;
            if (left != 0) left <= left - 1;
            if (mrd) begin
                word_l <= mem[maddr[7:2]];
                if (RL == 1) mrdat <= mem[maddr[7:2]];
                else left <= RL - 1;
            end
            if (mwr) begin
                for (int k = 0; k < 4; k++)
                    if (be[3-k]) mem[maddr[7:2]][31-8*k -: 8] <= mwd[31-8*k -: 8];
            end
        end

        exp_t        q[$];
        exp_t        e;
        int          ncyc    = 0;
        int          issue_n = -1;
        bit          busy    = 0;
        logic        ex_wr;
        logic [31:0] ex_addr, ex_wd, w;
        logic [3:0]  ex_be;
        string       pfx;

        initial pfx = $sformatf("L%0d", RL);

        always @(negedge clk) begin
            if (rst_chk) begin
                check_eq({pfx, " rst req_ready"}, 32'(rdy), 32'd1);
                check_eq({pfx, " rst resp_valid"}, 32'(rv), 32'd0);
                check_eq({pfx, " rst resp_error"}, 32'(rerr), 32'd0);
                check_eq({pfx, " rst resp_rdata"}, rdat, 32'd0);
                check_eq({pfx, " rst MemoryRead"}, 32'(mrd), 32'd0);
                check_eq({pfx, " rst MemoryWrite"}, 32'(mwr), 32'd0);
                check_eq({pfx, " rst byte_en"}, 32'(be), 32'd0);
                check_eq({pfx, " rst mem_addr"}, maddr, 32'd0);
                check_eq({pfx, " rst mem_wdata"}, mwd, 32'd0);
            end
            if (end_chk) check_eq({pfx, " drained"}, 32'(q.size()), 32'd0);
            if (mon_en) begin
                ncyc++;
                check_eq({pfx, " req_ready"}, 32'(rdy), 32'(!busy));
                check_eq({pfx, " MemoryRead"}, 32'(mrd), 32'((ncyc == issue_n) && !ex_wr));
                check_eq({pfx, " MemoryWrite"}, 32'(mwr), 32'((ncyc == issue_n) && ex_wr));
                if (ncyc == issue_n) begin
                    check_eq({pfx, " mem_addr"}, maddr, ex_addr);
                    check_eq({pfx, " byte_en"}, 32'(be), 32'(ex_be));
                    if (ex_wr) check_eq({pfx, " mem_wdata"}, mwd, ex_wd);
                end
                if (q.size() > 0 && q[0].due == ncyc) begin
                    check_eq({pfx, " resp_valid"}, 32'(rv), 32'd1);
                    e = q.pop_front();
                    if (rv) begin
                        check_eq({pfx, " resp_rdata"}, rdat, e.rdata);
                        check_eq({pfx, " resp_error"}, 32'(rerr), 32'(e.err));
                    end
                    busy = 0;
                end else begin
                    check_eq({pfx, " resp_valid"}, 32'(rv), 32'd0);
                end
                if (valid[g] && rdy && !rst) begin
                    int unsigned off, n;
                    off   = 32'(req_addr[1:0]);
                    n     = (req_size == 2'd0) ? 1 : (req_size == 2'd1) ? 2 : 4;
                    e.err = (req_size == 2'd3) || (req_size == 2'd1 && req_addr[0]) ||
                            (req_size == 2'd2 && req_addr[1:0] != 2'd0);
                    e.rdata = 32'h0;
                    e.due   = ncyc + (e.err ? 1 : req_write ? 2 : int'(RL) + 2);
                    ex_wr   = req_write;
                    ex_addr = {req_addr[31:2], 2'b00};
                    ex_be   = req_write ? 4'b0000 : 4'b1111;
                    ex_wd   = (n == 1) ? {4{req_wdata[7:0]}} : (n == 2) ? {2{req_wdata[15:0]}} : req_wdata;
                    w       = ref_mem[req_addr[7:2]];
                    if (!e.err && req_write) begin
                        for (int unsigned j = 0; j < n; j++) begin
                            w[31-8*(off+j) -: 8] = 8'(req_wdata >> ((n - 1 - j) * 8));
                            ex_be[3-(off+j)]     = 1'b1;
                        end
                        ref_mem[req_addr[7:2]] = w;
                    end else if (!e.err) begin
                        if (n == 1) begin
                            e.rdata = {24'h0, w[31-8*off -: 8]};
                            if (!req_unsigned && e.rdata[7]) e.rdata[31:8] = 24'hFFFFFF;
                        end else if (n == 2) begin
                            e.rdata = {16'h0, (off == 0) ? w[31:16] : w[15:0]};
                            if (!req_unsigned && e.rdata[15]) e.rdata[31:16] = 16'hFFFF;
                        end else begin
                            e.rdata = w;
                        end
                    end
                    issue_n = e.err ? -1 : ncyc + 1;
                    busy    = 1;
                    q.push_back(e);
                end
                if (rst) begin
                    q.delete();
                    busy    = 0;
                    issue_n = -1;
                end
            end
        end
    end

    task automatic send(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] d);
        logic [1:0] acc;
        @(posedge clk); #1;
        req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = d;
        valid = 2'b11;
        for (int k = 0; k < 40 && valid != 2'b00; k++) begin
            @(negedge clk);
            acc = valid & {g_dut[1].rdy, g_dut[0].rdy};
            @(posedge clk); #1;
            valid = valid & ~acc;
        end
        if (valid != 2'b00) begin
            check_eq("accept timeout", 32'(valid), 32'd0);
            valid = 2'b00;
        end
    endtask

    initial begin
        rst = 1'b1; valid = 2'b00; req_write = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; mon_en = 1'b0; rst_chk = 1'b0; end_chk = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0; rst_chk = 1'b1; mon_en = 1'b1;
        @(negedge clk); #1 rst_chk = 1'b0;

        // Stores, then the 0x1280FF34 pattern for loads
        send(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
        send(1'b1, 2'd0, 1'b0, 32'h13, 32'h000000A5);
        send(1'b1, 2'd1, 1'b0, 32'h12, 32'h00001234);
        send(1'b1, 2'd2, 1'b0, 32'h10, 32'h1280FF34);
        send(1'b0, 2'd0, 1'b0, 32'h11, 32'h0);
        send(1'b0, 2'd0, 1'b1, 32'h11, 32'h0);
        send(1'b0, 2'd1, 1'b0, 32'h12, 32'h0);
        send(1'b0, 2'd1, 1'b1, 32'h12, 32'h0);
        send(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        send(1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
        send(1'b1, 2'd0, 1'b0, 32'h20, 32'h00000080);
        send(1'b0, 2'd0, 1'b0, 32'h20, 32'h0);

        // Misaligned and reserved-size accesses
        send(1'b0, 2'd2, 1'b0, 32'h06, 32'h0);
        send(1'b0, 2'd1, 1'b0, 32'h03, 32'h0);
        send(1'b0, 2'd3, 1'b0, 32'h10, 32'h0);
        send(1'b1, 2'd1, 1'b0, 32'h11, 32'hFFFF);

        // Reset while both instances wait on read data
        send(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        send(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);

        // Request held high across RESP
        @(posedge clk); #1;
        req_write = 1'b0; req_size = 2'd1; req_unsigned = 1'b0; req_addr = 32'h12;
        valid = 2'b11;
        repeat (14) @(posedge clk);
        #1 valid = 2'b00;

        repeat (12) @(posedge clk);
        #1 end_chk = 1'b1;
        @(negedge clk); #1 end_chk = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
